handshake_ram_writer: RTL

//  Slave-side sink for the valid/ready data handshake. It is the write-side counterpart to the ROM-fed master.

---
 rtl/handshake_ram_writer.sv | 84 ++++++++
 1 files changed

// File: rtl/handshake_ram_writer.sv
// Valid/ready sink that buffers words in a 2-entry skid FIFO and writes them
// to consecutive RAM addresses from 0, raising done after DEPTH commits.
module handshake_ram_writer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              s_valid,
    input  logic [WIDTH-1:0]  s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_rdy,
    output logic [ADDR_W:0]   wr_count,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    logic [WIDTH-1:0] fifo_q [2];
    logic             head_q;
    logic             tail_q;
    logic [1:0]       count_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic [CNT_W-1:0] wr_count_q;
    logic             done_q;
    logic             push;
    logic             pop;

    // Handshake strobes depend only on flops plus en/clr/rst, never on s_valid.
    assign s_ready = ~rst & en & ~clr & ~done_q & (count_q < 2'd2) & (acc_cnt_q < DEPTH_C);
    assign mem_we  = ~rst & (count_q != 2'd0) & ~done_q & ~clr;

    assign push = s_valid & s_ready;
    assign pop  = mem_we & mem_rdy;

    assign mem_wdata = fifo_q[head_q];
    assign mem_addr  = wr_count_q[ADDR_W-1:0];
    assign wr_count  = wr_count_q;
    assign done      = done_q;

    // FIFO storage, pointers and capture counters; clr restarts without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            acc_cnt_q  <= '0;
            wr_count_q <= '0;
            done_q     <= 1'b0;
        end else if (clr) begin
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            acc_cnt_q  <= '0;
            wr_count_q <= '0;
            done_q     <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[tail_q] <= s_data;
                tail_q         <= ~tail_q;
                acc_cnt_q      <= acc_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                head_q     <= ~head_q;
                wr_count_q <= wr_count_q + CNT_W'(1);
                if (wr_count_q == LAST_C) begin
                    done_q <= 1'b1;
                end
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule
